// File: rtl/ax_bcc_skip_ctrl.sv
// Fetch-side skip controller fed by the approximate-BCC buffer hit vector.
// Define AX_SKIP_STATS_EN to add saturating skip/mispredict stat counters.
module ax_bcc_skip_ctrl #(
    parameter int FETCH_WIDTH     = 2,
    parameter int MAX_INFLIGHT    = 4,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int INSN_BYTE_WIDTH = 4,
    parameter int PC_WIDTH        = 32,
    localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FETCH_WIDTH-1:0] fetchValid,
    input  logic [FETCH_WIDTH-1:0] bufferHit,
    input  logic [PC_WIDTH-1:0]    fetchPC,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   resolveValid,
    input  logic                   resolveMispred,
    output logic                   skipValid,
    output logic [LANE_W-1:0]      skipLane,
    output logic [PC_WIDTH-1:0]    skipPC,
    output logic [FETCH_WIDTH-1:0] laneKeep,
    output logic [CNT_W-1:0]       inflightCount,
    output logic [1:0]             state
`ifdef AX_SKIP_STATS_EN
    ,
    output logic [31:0]            statSkipCount,
    output logic [31:0]            statMispredCount
`endif
);

    localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        THROTTLED = 2'd1,
        COOLDOWN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CD_W-1:0]        cd_q, cd_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   skip_valid_q, skip_valid_d;
    logic [LANE_W-1:0]      skip_lane_q, skip_lane_d;
    logic [PC_WIDTH-1:0]    skip_pc_q, skip_pc_d;
    logic [FETCH_WIDTH-1:0] lane_keep_q, lane_keep_d;

    logic [FETCH_WIDTH-1:0] hit_vec;
    logic                   cand_found;
    logic [LANE_W-1:0]      cand_lane;
    logic [PC_WIDTH-1:0]    pc_off;
    logic                   issue;
    logic                   mispred;
    logic                   at_max;

    // Masking with fetchValid keeps X from invalid lanes out of the pick.
    always_comb begin
        hit_vec    = fetchValid & bufferHit;
        cand_found = 1'b0;
        cand_lane  = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                cand_found = 1'b1;
                cand_lane  = LANE_W'(i);
            end
        end
    end

    assign issue = cand_found
                && (state_q == ARMED)
                && (count_q < CNT_W'(MAX_INFLIGHT))
                && !stall
                && !flush;

    assign mispred = resolveValid && resolveMispred;
    assign pc_off  = PC_WIDTH'(cand_lane) * PC_WIDTH'(INSN_BYTE_WIDTH);

    always_comb begin
        skip_valid_d = issue;
        skip_lane_d  = '0;
        skip_pc_d    = '0;
        lane_keep_d  = '1;
        if (issue) begin
            skip_lane_d = cand_lane;
            skip_pc_d   = fetchPC + pc_off;
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                lane_keep_d[j] = (LANE_W'(j) <= cand_lane);
            end
        end
    end

    // A resolve against an empty budget is dropped rather than underflowing.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (issue && !resolveValid) begin
            count_d = count_q + CNT_W'(1);
        end else if (!issue && resolveValid && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign at_max = (count_d == CNT_W'(MAX_INFLIGHT));

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        if (mispred) begin
            state_d = COOLDOWN;
            cd_d    = CD_W'(COOLDOWN_CYCLES - 1);
        end else begin
            case (state_q)
                ARMED: begin
                    if (at_max) state_d = THROTTLED;
                end
                THROTTLED: begin
                    if (!at_max) state_d = ARMED;
                end
                COOLDOWN: begin
                    if (cd_q != '0) begin
                        cd_d = cd_q - CD_W'(1);
                    end else begin
                        state_d = at_max ? THROTTLED : ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARMED;
            cd_q         <= '0;
            count_q      <= '0;
            skip_valid_q <= 1'b0;
            skip_lane_q  <= '0;
            skip_pc_q    <= '0;
            lane_keep_q  <= '1;
        end else begin
            state_q      <= state_d;
            cd_q         <= cd_d;
            count_q      <= count_d;
            skip_valid_q <= skip_valid_d;
            skip_lane_q  <= skip_lane_d;
            skip_pc_q    <= skip_pc_d;
            lane_keep_q  <= lane_keep_d;
        end
    end

    assign skipValid     = skip_valid_q;
    assign skipLane      = skip_lane_q;
    assign skipPC        = skip_pc_q;
    assign laneKeep      = lane_keep_q;
    assign inflightCount = count_q;
    assign state         = state_q;

`ifdef AX_SKIP_STATS_EN
    logic [31:0] stat_skip_q;
    logic [31:0] stat_misp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_skip_q <= '0;
            stat_misp_q <= '0;
        end else begin
            if (issue && (stat_skip_q != '1)) begin
                stat_skip_q <= stat_skip_q + 32'd1;
            end
            if (mispred && (stat_misp_q != '1)) begin
                stat_misp_q <= stat_misp_q + 32'd1;
            end
        end
    end

    assign statSkipCount    = stat_skip_q;
    assign statMispredCount = stat_misp_q;
`endif

endmodule
